// File: rtl/seq_loop_mon_pkg.sv
// Shared types and helpers for the sequential-loop monitor.
// Optional build macro used by the top: SEQ_LOOP_MON_MINMAX_EN.
package seq_loop_mon_pkg;

  // Monitor FSM encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] mon_state_e;
  localparam mon_state_e StIdle = 2'd0;
  localparam mon_state_e StLoop = 2'd1;
  localparam mon_state_e StDone = 2'd2;

  // Saturating increment for counters up to 64 bits wide; sticks at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/seq_loop_monitor_match.sv
// Set-membership matcher: hit when any enabled entry equals the probed state.
module state_set_match #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 2
) (
  input  logic [N*W-1:0] entries_i,
  input  logic [N-1:0]   valid_i,
  input  logic [W-1:0]   state_i,
  output logic           hit_o
);

  // OR-reduce over the enabled entries.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (valid_i[i] && (entries_i[i*W +: W] == state_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_loop_monitor.sv
// Cycle-accurate monitor for one sequential loop of an HLS FSM.
// Define SEQ_LOOP_MON_MINMAX_EN to add trip_min/trip_max outputs.
module seq_loop_monitor
  import seq_loop_mon_pkg::*;
#(
  parameter int unsigned FSM_WIDTH    = 2,
  parameter int unsigned NUM_PRE      = 2,
  parameter int unsigned NUM_POST     = 2,
  parameter int unsigned NUM_QUIT     = 1,
  parameter int unsigned NUM_ITER_END = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [FSM_WIDTH-1:0]            cur_state,
  input  logic [NUM_PRE-1:0]              pre_states_valid,
  input  logic [NUM_PRE*FSM_WIDTH-1:0]    pre_loop_states,
  input  logic [NUM_POST-1:0]             post_states_valid,
  input  logic [NUM_POST*FSM_WIDTH-1:0]   post_loop_states,
  input  logic [NUM_QUIT-1:0]             quit_states_valid,
  input  logic [NUM_QUIT*FSM_WIDTH-1:0]   quit_loop_states,
  input  logic [FSM_WIDTH-1:0]            iter_start_state,
  input  logic [NUM_ITER_END-1:0]         iter_end_states_valid,
  input  logic [NUM_ITER_END*FSM_WIDTH-1:0] iter_end_states,
  input  logic                            one_state_loop,
  input  logic                            finish,
  output logic                            in_loop,
  output logic                            loop_start,
  output logic                            iter_done,
  output logic                            loop_exit,
  output logic [CNT_WIDTH-1:0]            iter_count,
  output logic [CNT_WIDTH-1:0]            trip_count,
  output logic                            trip_valid,
  output logic [CNT_WIDTH-1:0]            loop_count,
`ifdef SEQ_LOOP_MON_MINMAX_EN
  output logic [CNT_WIDTH-1:0]            trip_min,
  output logic [CNT_WIDTH-1:0]            trip_max,
`endif
  output logic                            err_illegal,
  output logic                            done
);

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    return CNT_WIDTH'(sat_inc(64'(v), CNT_WIDTH));
  endfunction

  logic [FSM_WIDTH-1:0] prev_q;
  mon_state_e           state_q, state_d;
  logic                 in_loop_q, in_loop_d;
  logic                 loop_start_q, loop_start_d;
  logic                 iter_done_q, iter_done_d;
  logic                 loop_exit_q, loop_exit_d;
  logic [CNT_WIDTH-1:0] iter_count_q, iter_count_d;
  logic [CNT_WIDTH-1:0] trip_count_q, trip_count_d;
  logic                 trip_valid_q, trip_valid_d;
  logic [CNT_WIDTH-1:0] loop_count_q, loop_count_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  logic [CNT_WIDTH-1:0] trip_min_q, trip_min_d;
  logic [CNT_WIDTH-1:0] trip_max_q, trip_max_d;
`endif

  logic pre_hit, post_hit, quit_hit, iter_end_hit;
  logic entry, iter_end;
  logic [CNT_WIDTH-1:0] trip_val;

  // Pre and quit sets are judged on the previous state, post and iter-end on the current one.
  state_set_match #(.N(NUM_PRE), .W(FSM_WIDTH)) u_pre (
    .entries_i(pre_loop_states), .valid_i(pre_states_valid), .state_i(prev_q), .hit_o(pre_hit)
  );
  state_set_match #(.N(NUM_POST), .W(FSM_WIDTH)) u_post (
    .entries_i(post_loop_states), .valid_i(post_states_valid), .state_i(cur_state),
    .hit_o(post_hit)
  );
  state_set_match #(.N(NUM_QUIT), .W(FSM_WIDTH)) u_quit (
    .entries_i(quit_loop_states), .valid_i(quit_states_valid), .state_i(prev_q),
    .hit_o(quit_hit)
  );
  state_set_match #(.N(NUM_ITER_END), .W(FSM_WIDTH)) u_iter_end (
    .entries_i(iter_end_states), .valid_i(iter_end_states_valid), .state_i(cur_state),
    .hit_o(iter_end_hit)
  );

  assign entry    = pre_hit && (cur_state == iter_start_state);
  assign iter_end = one_state_loop ? ((cur_state == iter_start_state) &&
                                      (prev_q == iter_start_state))
                                   : iter_end_hit;
  // An iteration finishing on the exit cycle still counts toward the trip.
  assign trip_val = iter_end ? cnt_inc(iter_count_q) : iter_count_q;

  // Next-state logic: finish dominates, re-entry only flags an error.
  always_comb begin
    state_d      = state_q;
    in_loop_d    = in_loop_q;
    loop_start_d = 1'b0;
    iter_done_d  = 1'b0;
    loop_exit_d  = 1'b0;
    iter_count_d = iter_count_q;
    trip_count_d = trip_count_q;
    trip_valid_d = trip_valid_q;
    loop_count_d = loop_count_q;
    err_d        = err_q;
    done_d       = done_q;
`ifdef SEQ_LOOP_MON_MINMAX_EN
    trip_min_d   = trip_min_q;
    trip_max_d   = trip_max_q;
`endif
    if (finish) begin
      state_d   = StDone;
      in_loop_d = 1'b0;
      done_d    = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (entry) begin
            state_d      = StLoop;
            in_loop_d    = 1'b1;
            loop_start_d = 1'b1;
            iter_count_d = '0;
          end
        end
        StLoop: begin
          if (entry) begin
            err_d = 1'b1;
          end else begin
            if (iter_end) begin
              iter_done_d  = 1'b1;
              iter_count_d = cnt_inc(iter_count_q);
            end
            if (post_hit) begin
              state_d      = StIdle;
              in_loop_d    = 1'b0;
              loop_exit_d  = 1'b1;
              trip_count_d = trip_val;
              trip_valid_d = 1'b1;
              loop_count_d = cnt_inc(loop_count_q);
              if ((|quit_states_valid) && !quit_hit) err_d = 1'b1;
`ifdef SEQ_LOOP_MON_MINMAX_EN
              if (trip_val < trip_min_q) trip_min_d = trip_val;
              if (trip_val > trip_max_q) trip_max_d = trip_val;
`endif
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q       <= '0;
      state_q      <= StIdle;
      in_loop_q    <= 1'b0;
      loop_start_q <= 1'b0;
      iter_done_q  <= 1'b0;
      loop_exit_q  <= 1'b0;
      iter_count_q <= '0;
      trip_count_q <= '0;
      trip_valid_q <= 1'b0;
      loop_count_q <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      trip_min_q   <= '1;
      trip_max_q   <= '0;
`endif
    end else begin
      prev_q       <= cur_state;
      state_q      <= state_d;
      in_loop_q    <= in_loop_d;
      loop_start_q <= loop_start_d;
      iter_done_q  <= iter_done_d;
      loop_exit_q  <= loop_exit_d;
      iter_count_q <= iter_count_d;
      trip_count_q <= trip_count_d;
      trip_valid_q <= trip_valid_d;
      loop_count_q <= loop_count_d;
      err_q        <= err_d;
      done_q       <= done_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      trip_min_q   <= trip_min_d;
      trip_max_q   <= trip_max_d;
`endif
    end
  end

  assign in_loop     = in_loop_q;
  assign loop_start  = loop_start_q;
  assign iter_done   = iter_done_q;
  assign loop_exit   = loop_exit_q;
  assign iter_count  = iter_count_q;
  assign trip_count  = trip_count_q;
  assign trip_valid  = trip_valid_q;
  assign loop_count  = loop_count_q;
  assign err_illegal = err_q;
  assign done        = done_q;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  assign trip_min    = trip_min_q;
  assign trip_max    = trip_max_q;
`endif

endmodule
